// File: rtl/medidor_periodo.sv
// medidor_periodo: measures the period of a slow asynchronous square wave in clk cycles
// and hands each result out over a valid/ready handshake.
// Optional feature: define MEDIDOR_PROMEDIO4_EN to present the floor average of every
// four consecutive captures instead of each capture.
module medidor_periodo #(
  parameter int unsigned CNT_W   = 23,
  parameter int unsigned TIMEOUT = 8000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  output logic [CNT_W-1:0] periodo,
  output logic             valid,
  input  logic             ready,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StMeas} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;

  logic             s1_q, s2_q, s3_q;
  // Marks which sync stages hold post-reset samples, so a level that is already high at
  // reset release is not mistaken for a rising edge.
  logic [2:0]       fill_q;
  logic             edge_det;

  logic             capture;
  logic             timeout_hit;
  logic             present;
  logic [CNT_W-1:0] result;

  logic [CNT_W-1:0] periodo_q, periodo_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

`ifdef MEDIDOR_PROMEDIO4_EN
  logic [CNT_W+1:0] sum_q, sum_d;
  logic [1:0]       nmues_q, nmues_d;
  logic [CNT_W+1:0] sum_total;
`endif

  assign edge_det = s2_q & ~s3_q & fill_q[2];

  // Input synchronizer and edge-detect history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= 3'b000;
    end else begin
      s1_q   <= s_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // Measurement FSM next state: count clk cycles between rising edges, give up at timeout.
  always_comb begin
    state_d     = state_q;
    cuenta_d    = cuenta_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      StIdle: begin
        cuenta_d = '0;
        if (edge_det) begin
          state_d  = StMeas;
          cuenta_d = CNT_W'(1);
        end
      end
      StMeas: begin
        if (edge_det) begin
          capture  = 1'b1;
          cuenta_d = CNT_W'(1);
        end else if (cuenta_q == TimeoutC) begin
          timeout_hit = 1'b1;
          cuenta_d    = '0;
          state_d     = StIdle;
        end else begin
          cuenta_d = cuenta_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        cuenta_d = '0;
      end
    endcase
  end

`ifdef MEDIDOR_PROMEDIO4_EN
  // Accumulate four captures; only the fourth presents a (floor) averaged result.
  always_comb begin
    sum_total = sum_q + {2'b00, cuenta_q};
    sum_d     = sum_q;
    nmues_d   = nmues_q;
    present   = capture && (nmues_q == 2'd3);
    result    = sum_total[CNT_W+1:2];
    if (timeout_hit) begin
      sum_d   = '0;
      nmues_d = 2'd0;
    end else if (capture) begin
      if (nmues_q == 2'd3) begin
        sum_d   = '0;
        nmues_d = 2'd0;
      end else begin
        sum_d   = sum_total;
        nmues_d = nmues_q + 2'd1;
      end
    end
  end
`else
  // Every capture is presented directly.
  always_comb begin
    present = capture;
    result  = cuenta_q;
  end
`endif

  // Output handshake: load a new result when the slot is free or being accepted now.
  always_comb begin
    periodo_d = periodo_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    if (timeout_hit) begin
      timeout_d = 1'b1;
    end
    if (present) begin
      if (!valid_q || ready) begin
        periodo_d = result;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cuenta_q  <= '0;
      periodo_q <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef MEDIDOR_PROMEDIO4_EN
      sum_q     <= '0;
      nmues_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cuenta_q  <= cuenta_d;
      periodo_q <= periodo_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
`ifdef MEDIDOR_PROMEDIO4_EN
      sum_q     <= sum_d;
      nmues_q   <= nmues_d;
`endif
    end
  end

  assign periodo = periodo_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_medidor_periodo.sv
// Directed self-checking bench for medidor_periodo (TIMEOUT overridden to 100).
module tb_medidor_periodo;

  localparam int unsigned CNT_W = 23;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_in;
  logic             ready;
  logic [CNT_W-1:0] periodo;
  logic             valid;
  logic             timeout;
  logic             overrun;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Statistics gathered while driving the wave.
  int unsigned      nvalid;
  logic [CNT_W-1:0] last_p, pmin, pmax;

  medidor_periodo #(
    .CNT_W  (CNT_W),
    .TIMEOUT(100)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .s_in   (s_in),
    .periodo(periodo),
    .valid  (valid),
    .ready  (ready),
    .timeout(timeout),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    nvalid = 0;
    last_p = '0;
    pmin   = '1;
    pmax   = '0;
  endtask

  // Hold s_in at lvl for n cycles, recording every cycle where valid is high.
  task automatic seg(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      s_in = lvl;
      tick();
      if (valid) begin
        nvalid++;
        last_p = periodo;
        if (periodo < pmin) pmin = periodo;
        if (periodo > pmax) pmax = periodo;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    s_in  = 1'b0;
    ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in = (i % 2 == 1);
      tick();
    end
    checks++; if (periodo !== '0) $display("FAIL reset_periodo: got %0d want 0", periodo); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
    checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
    // Release with s_in already high: that level must not count as an edge.
    s_in  = 1'b1;
    reset = 1'b1;
    clr_stats();
    seg(1'b1, 10);
    checks++; if (nvalid !== 0) $display("FAIL release_high: got %0d valid cycles want 0", nvalid); else passed++;
`ifndef MEDIDOR_PROMEDIO4_EN
    seg(1'b0, 5); seg(1'b1, 5); seg(1'b0, 5);
    checks++; if (nvalid !== 0) $display("FAIL first_edge: got %0d valid cycles want 0", nvalid); else passed++;
    seg(1'b1, 5);
    checks++; if (nvalid !== 1) $display("FAIL second_edge_count: got %0d want 1", nvalid); else passed++;
    checks++; if (last_p !== 10) $display("FAIL second_edge_periodo: got %0d want 10", last_p); else passed++;
`endif
  endtask

  task automatic test_steady();
    do_reset();
    ready = 1'b1;
    clr_stats();
    for (int i = 0; i < 6; i++) begin
      seg(1'b1, 5);
      seg(1'b0, 5);
    end
    checks++; if (nvalid !== 5) $display("FAIL steady_count: got %0d want 5", nvalid); else passed++;
    checks++; if (pmin !== 10) $display("FAIL steady_pmin: got %0d want 10", pmin); else passed++;
    checks++; if (pmax !== 10) $display("FAIL steady_pmax: got %0d want 10", pmax); else passed++;
    checks++; if (timeout !== 1'b0) $display("FAIL steady_timeout: got %b want 0", timeout); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL steady_overrun: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    clr_stats();
    for (int i = 0; i < 3; i++) begin
      seg(1'b1, 5);
      seg(1'b0, 5);
    end
    seg(1'b1, 5);
    seg(1'b0, 4);
    checks++; if (valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", valid); else passed++;
    checks++; if (periodo !== 10) $display("FAIL bp_periodo: got %0d want 10", periodo); else passed++;
    checks++; if (pmin !== 10 || pmax !== 10) $display("FAIL bp_stable: got min %0d max %0d want 10", pmin, pmax); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun); else passed++;
    ready = 1'b1;
    seg(1'b0, 1);
    checks++; if (valid !== 1'b0) $display("FAIL accept_valid: got %b want 0", valid); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL accept_overrun: got %b want 0", overrun); else passed++;
    clr_stats();
    seg(1'b1, 5);
    seg(1'b0, 5);
    checks++; if (nvalid !== 1) $display("FAIL after_accept_count: got %0d want 1", nvalid); else passed++;
    checks++; if (last_p !== 10) $display("FAIL after_accept_periodo: got %0d want 10", last_p); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    ready = 1'b1;
    clr_stats();
    // s_in goes high just after edge T0; measurement starts at T3, timeout fires at T103.
    seg(1'b1, 5);
    seg(1'b0, 97);
    checks++; if (timeout !== 1'b0) $display("FAIL timeout_early: got %b want 0", timeout); else passed++;
    seg(1'b0, 1);
    checks++; if (timeout !== 1'b1) $display("FAIL timeout_fire: got %b want 1", timeout); else passed++;
    clr_stats();
    seg(1'b1, 6);
    seg(1'b0, 6);
    checks++; if (nvalid !== 0) $display("FAIL restart_no_result: got %0d want 0", nvalid); else passed++;
    checks++; if (timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout); else passed++;
    seg(1'b1, 6); seg(1'b0, 6); seg(1'b1, 6); seg(1'b0, 6);
    checks++; if (nvalid !== 2) $display("FAIL restart_count: got %0d want 2", nvalid); else passed++;
    checks++; if (pmin !== 12 || pmax !== 12) $display("FAIL restart_periodo: got min %0d max %0d want 12", pmin, pmax); else passed++;
    checks++; if (timeout !== 1'b0) $display("FAIL timeout_clear: got %b want 0", timeout); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b1;
    clr_stats();
    seg(1'b1, 8);
    reset = 1'b0;
    seg(1'b1, 2);
    reset = 1'b1;
    checks++; if (valid !== 1'b0 || periodo !== '0) $display("FAIL mid_reset_out: got valid %b periodo %0d want 0 0", valid, periodo); else passed++;
    seg(1'b0, 10); seg(1'b1, 10); seg(1'b0, 10);
    checks++; if (nvalid !== 0) $display("FAIL mid_reset_first_edge: got %0d want 0", nvalid); else passed++;
    seg(1'b1, 10);
    checks++; if (nvalid !== 1) $display("FAIL mid_reset_count: got %0d want 1", nvalid); else passed++;
    checks++; if (last_p !== 20) $display("FAIL mid_reset_periodo: got %0d want 20", last_p); else passed++;
  endtask

  task automatic test_promedio();
    do_reset();
    ready = 1'b1;
    clr_stats();
    seg(1'b1, 5); seg(1'b0, 5);
    seg(1'b1, 5); seg(1'b0, 5);
    seg(1'b1, 6); seg(1'b0, 6);
    seg(1'b1, 6); seg(1'b0, 7);
    checks++; if (nvalid !== 0) $display("FAIL avg_no_partial: got %0d want 0", nvalid); else passed++;
    seg(1'b1, 5); seg(1'b0, 5);
    checks++; if (nvalid !== 1) $display("FAIL avg_count: got %0d want 1", nvalid); else passed++;
    checks++; if (last_p !== 11) $display("FAIL avg_periodo: got %0d want 11", last_p); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL avg_overrun: got %b want 0", overrun); else passed++;
  endtask

  initial begin
    reset = 1'b0;
    s_in  = 1'b0;
    ready = 1'b0;
    clr_stats();
    test_reset();
`ifdef MEDIDOR_PROMEDIO4_EN
    test_promedio();
`else
    test_steady();
    test_backpressure();
    test_timeout();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/medidor_periodo.md
# medidor_periodo

Measures the period of a slow, asynchronous square wave in `clk` cycles and delivers each result over a valid/ready handshake. It is the receiving end of our clock dividers: it checks and monitors divided clocks such as `s_clk`, or any external slow clock, against the system clock. Results feed the display and supervision logic. A timeout flags a stopped input.

## Interface
- `CNT_W`, 23: width of the period counter and result.
- `TIMEOUT`, 23'd8000000: cycles without a rising edge before the timeout fires; must be ≤ 2^CNT_W − 1.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `s_in` input 1: asynchronous square wave to measure.
- `periodo` output CNT_W: last captured period, in `clk` cycles.
- `valid` output 1: `periodo` holds an unaccepted result.
- `ready` input 1: consumer accepts the result when `valid && ready`.
- `timeout` output 1: sticky; no rising edge seen within `TIMEOUT` cycles.
- `overrun` output 1: sticky; a result was dropped because the previous one was still pending.

## Operation
- Input path:
  - 3-flop chain: `s1<=s_in`, `s2<=s1`, `s3<=s2`.
  - `edge = s2 & ~s3`.
  - All three flops reset to 0.
  - If `s_in` is high at reset release, no edge is seen until it goes low and then high again.
- FSM with 2 states:
  - IDLE: `cuenta` is held at 0. On `edge` → go to MEAS and set `cuenta<=1`.
  - MEAS, no `edge`: `cuenta<=cuenta+1`.
  - MEAS, `edge`: capture `cuenta` as the period P, then set `cuenta<=1` and stay in MEAS.
  - MEAS, `cuenta==TIMEOUT` and no `edge`: set `timeout<=1`, `cuenta<=0` and go to IDLE. The next edge restarts measurement without producing a result.
- Arithmetic:
  - P equals the number of `clk` cycles between two consecutive detected rising edges.
  - `cuenta` cannot wrap, because the timeout fires first.
  - Minimum measurable period is 4 clk, with the input high ≥2 and low ≥2 clk. Shorter periods are unspecified.
- Handshake:
  - On capture with `valid==0`: `periodo<=P`, `valid<=1`, `timeout<=0`.
  - On capture with `valid==1` and no accept in the same cycle: P is dropped, `periodo` is unchanged, and `overrun<=1`.
  - Capture in the same cycle as an accept (`valid&&ready`): the new P is loaded and `valid` stays 1.
  - Accept with no capture: `valid<=0` and `overrun<=0`.
  - `periodo` is stable while `valid==1`.
- Reset (`reset==0` at a clk edge, including mid-measurement):
  - State IDLE, `cuenta` 0, sync flops 0.
  - `periodo` 0, `valid` 0, `timeout` 0, `overrun` 0.
  - Any pending result is lost.

## Timing
- Latency: `s_in` first sampled high at clk edge k → `edge` true in the cycle after edge k+1 → `valid` (and `periodo`) update at edge k+2.
- Throughput: one result per input period. Back-to-back accepts are allowed (`ready` tied high).
- `timeout` rises `TIMEOUT` cycles after the last edge that entered or stayed in MEAS, and clears on the next captured result.
- All outputs are registered; there is no combinational path from `ready` or `s_in` to any output.

## Configuration
- Macro `MEDIDOR_PROMEDIO4_EN`.
- Defined:
  - Captures accumulate into a CNT_W+2-bit sum plus a 2-bit sample count.
  - Every 4th capture presents `periodo = sum>>2` (floor) and clears the sum; `valid`/`overrun` apply to this averaged result only.
  - Timeout or reset clears the sum and the sample count.
  - Latency from the 4th edge is unchanged.
- Undefined: every capture is presented directly, as described above.

## Test plan
- Reset: hold `reset=0` for 5 clk with `s_in` toggling → all outputs 0. Release with `s_in` high → no `valid` until a low→high transition.
- Steady wave, 5 clk high / 5 low, `ready=1` → `periodo=10` on every period from the second rising edge on; `timeout=0`, `overrun=0`.
- Backpressure: `ready=0` across 3 periods of 10 → `periodo` holds the first 10 and `overrun=1`. Then `ready=1` for one cycle → `valid=0`, `overrun=0` that cycle, with the next capture following normally.
- Timeout with `TIMEOUT=100` and `s_in` stuck low after an edge → `timeout=1` exactly 100 cycles after that edge. Restart at period 12 → the first result after two edges is `periodo=12` and `timeout` clears.
- Reset mid-measurement: `reset=0` at `cuenta=6` of a period-20 wave → no result is emitted. After release, the first result arrives only after two new rising edges and equals 20.
- With `MEDIDOR_PROMEDIO4_EN` defined: periods 10, 10, 12, 13 → a single `valid` with `periodo=11`. No `valid` occurs between the individual captures.
